// File: rtl/mem_stage_if.sv
// Bundle between the EX/MEM register, the data RAM and WB as seen by the MEM stage.
interface mem_stage_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned REG_AW = 5
) ();
   logic              in_valid_i;
   logic              we_i;
   logic [REG_AW-1:0] waddr_i;
   logic [31:0]       wdata_i;
   logic [3:0]        mem_op_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [31:0]       mem_data_i;
   logic [31:0]       ram_rdata_i;
   logic              ram_ack_i;
   logic              ram_ce_o;
   logic              ram_we_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [3:0]        ram_sel_o;
   logic [31:0]       ram_wdata_o;
   logic              stall_o;
   logic              we_o;
   logic [REG_AW-1:0] waddr_o;
   logic [31:0]       wdata_o;
   logic              exc_o;
   logic [1:0]        exc_code_o;
   logic [ADDR_W-1:0] exc_addr_o;

   modport slave (
      input  in_valid_i, we_i, waddr_i, wdata_i, mem_op_i, mem_addr_i, mem_data_i,
      input  ram_rdata_i, ram_ack_i,
      output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o, stall_o,
      output we_o, waddr_o, wdata_o, exc_o, exc_code_o, exc_addr_o
   );

   modport master (
      output in_valid_i, we_i, waddr_i, wdata_i, mem_op_i, mem_addr_i, mem_data_i,
      output ram_rdata_i, ram_ack_i,
      input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o, stall_o,
      input  we_o, waddr_o, wdata_o, exc_o, exc_code_o, exc_addr_o
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Registered, handshaked MEM stage: one outstanding RAM access at a time, load
// extension, misalignment and bus-timeout exceptions, results registered to WB.
module mem_stage_ctrl #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned TIMEOUT = 16
) (
   input logic        clk,
   input logic        rst,
   mem_stage_if.slave bus
);
   localparam logic [3:0] OpLb  = 4'd1;
   localparam logic [3:0] OpLbu = 4'd2;
   localparam logic [3:0] OpLh  = 4'd3;
   localparam logic [3:0] OpLhu = 4'd4;
   localparam logic [3:0] OpLw  = 4'd5;
   localparam logic [3:0] OpSb  = 4'd6;
   localparam logic [3:0] OpSh  = 4'd7;
   localparam logic [3:0] OpSw  = 4'd8;
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   function automatic logic op_is_load(input logic [3:0] op);
      return (op >= OpLb) && (op <= OpLw);
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return (op >= OpSb) && (op <= OpSw);
   endfunction

   function automatic logic op_is_byte(input logic [3:0] op);
      return (op == OpLb) || (op == OpLbu) || (op == OpSb);
   endfunction

   function automatic logic op_is_half(input logic [3:0] op);
      return (op == OpLh) || (op == OpLhu) || (op == OpSh);
   endfunction

   state_e            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [REG_AW-1:0] waddr_q, waddr_d;
   logic              we_q, we_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              wb_we_q, wb_we_d;
   logic [REG_AW-1:0] wb_waddr_q, wb_waddr_d;
   logic [31:0]       wb_wdata_q, wb_wdata_d;
   logic              exc_q, exc_d;
   logic [1:0]        exc_code_q, exc_code_d;
   logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;

   logic        busy, in_mem, in_mis, in_accept, timeout_hit;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign busy   = (state_q == StBusy);
   assign in_mem = op_is_load(bus.mem_op_i) || op_is_store(bus.mem_op_i);
   assign in_mis = (op_is_half(bus.mem_op_i) && bus.mem_addr_i[0]) ||
                   (((bus.mem_op_i == OpLw) || (bus.mem_op_i == OpSw)) &&
                    (bus.mem_addr_i[1:0] != 2'b00));
   assign in_accept = bus.in_valid_i && in_mem && !in_mis;
   // An ack in the final counted cycle takes priority over the abort.
   assign timeout_hit = busy && (TIMEOUT != 0) && !bus.ram_ack_i &&
                        (cnt_q == CntW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (in_accept) state_d = StBusy;
         StBusy:  if (bus.ram_ack_i || timeout_hit) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ld_byte = bus.ram_rdata_i[7:0];
      case (addr_q[1:0])
         2'd1:    ld_byte = bus.ram_rdata_i[15:8];
         2'd2:    ld_byte = bus.ram_rdata_i[23:16];
         2'd3:    ld_byte = bus.ram_rdata_i[31:24];
         default: ld_byte = bus.ram_rdata_i[7:0];
      endcase
      ld_half = addr_q[1] ? bus.ram_rdata_i[31:16] : bus.ram_rdata_i[15:0];
      case (op_q)
         OpLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         OpLbu:   ld_data = {24'h0, ld_byte};
         OpLh:    ld_data = {{16{ld_half[15]}}, ld_half};
         OpLhu:   ld_data = {16'h0, ld_half};
         default: ld_data = bus.ram_rdata_i;
      endcase
   end

   always_comb begin
      op_d       = op_q;
      addr_d     = addr_q;
      data_d     = data_q;
      waddr_d    = waddr_q;
      we_d       = we_q;
      cnt_d      = cnt_q;
      wb_we_d    = 1'b0;
      wb_waddr_d = wb_waddr_q;
      wb_wdata_d = wb_wdata_q;
      exc_d      = 1'b0;
      exc_code_d = 2'd0;
      exc_addr_d = exc_addr_q;
      case (state_q)
         StIdle: begin
            if (bus.in_valid_i && !in_mem) begin
               wb_we_d    = bus.we_i;
               wb_waddr_d = bus.waddr_i;
               wb_wdata_d = bus.wdata_i;
            end else if (bus.in_valid_i && in_mis) begin
               exc_d      = 1'b1;
               exc_code_d = op_is_load(bus.mem_op_i) ? 2'd1 : 2'd2;
               exc_addr_d = bus.mem_addr_i;
            end else if (in_accept) begin
               op_d    = bus.mem_op_i;
               addr_d  = bus.mem_addr_i;
               data_d  = bus.mem_data_i;
               waddr_d = bus.waddr_i;
               we_d    = bus.we_i;
               cnt_d   = '0;
            end
         end
         StBusy: begin
            if (bus.ram_ack_i) begin
               if (op_is_load(op_q)) begin
                  wb_we_d    = we_q;
                  wb_waddr_d = waddr_q;
                  wb_wdata_d = ld_data;
               end
            end else if (timeout_hit) begin
               exc_d      = 1'b1;
               exc_code_d = 2'd3;
               exc_addr_d = addr_q;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         waddr_q    <= '0;
         we_q       <= 1'b0;
         cnt_q      <= '0;
         wb_we_q    <= 1'b0;
         wb_waddr_q <= '0;
         wb_wdata_q <= '0;
         exc_q      <= 1'b0;
         exc_code_q <= 2'd0;
         exc_addr_q <= '0;
      end else begin
         op_q       <= op_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         waddr_q    <= waddr_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         wb_we_q    <= wb_we_d;
         wb_waddr_q <= wb_waddr_d;
         wb_wdata_q <= wb_wdata_d;
         exc_q      <= exc_d;
         exc_code_q <= exc_code_d;
         exc_addr_q <= exc_addr_d;
      end
   end

   always_comb begin
      bus.ram_ce_o    = busy;
      bus.ram_we_o    = busy && op_is_store(op_q);
      bus.ram_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
      bus.ram_sel_o   = 4'b0000;
      bus.ram_wdata_o = data_q;
      if (op_is_byte(op_q)) begin
         bus.ram_sel_o   = 4'b0001 << addr_q[1:0];
         bus.ram_wdata_o = {4{data_q[7:0]}};
      end else if (op_is_half(op_q)) begin
         bus.ram_sel_o   = addr_q[1] ? 4'b1100 : 4'b0011;
         bus.ram_wdata_o = {2{data_q[15:0]}};
      end else if (op_is_load(op_q) || op_is_store(op_q)) begin
         bus.ram_sel_o = 4'b1111;
      end
      if (!busy) bus.ram_sel_o = 4'b0000;
      bus.stall_o    = busy ? (!bus.ram_ack_i && !timeout_hit) : in_accept;
      bus.we_o       = wb_we_q;
      bus.waddr_o    = wb_waddr_q;
      bus.wdata_o    = wb_wdata_q;
      bus.exc_o      = exc_q;
      bus.exc_code_o = exc_code_q;
      bus.exc_addr_o = exc_addr_q;
   end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Parametrised MEM pipeline stage for GeMIPS. It replaces the purely combinational memory stage with a registered, handshaked stage that supports:
- byte, halfword and word loads and stores, with load sign/zero extension;
- variable-latency RAM through a request/acknowledge handshake;
- misalignment detection and a bus timeout.

It sits between the EX/MEM register and the WB stage. It drives the data RAM port and raises a stall to freeze upstream stages while an access is outstanding.

Parameters:
ADDR_W, 32, data RAM address width (address bits [1:0] select the byte lane)
REG_AW, 5, register-file write-address width
TIMEOUT, 16, max BUSY cycles without ram_ack_i before abort; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
in_valid_i  in  1  EX/MEM holds a valid instruction
we_i  in  1  register write enable from EX
waddr_i  in  REG_AW  destination register
wdata_i  in  32  ALU result (used for non-memory ops)
mem_op_i  in  4  0=NONE 1=LB 2=LBU 3=LH 4=LHU 5=LW 6=SB 7=SH 8=SW; 9-15 treated as NONE
mem_addr_i  in  ADDR_W  effective address
mem_data_i  in  32  store data (rt)
ram_rdata_i  in  32  RAM read data, valid when ram_ack_i=1
ram_ack_i  in  1  RAM completes the current access
ram_ce_o  out  1  RAM request
ram_we_o  out  1  1=write, 0=read
ram_addr_o  out  ADDR_W  word-aligned address (bits [1:0] forced to 0)
ram_sel_o  out  4  byte enables, active-high, bit k = byte lane k
ram_wdata_o  out  32  store data replicated across lanes
stall_o  out  1  hold EX/MEM and earlier stages
we_o  out  1  to WB, registered
waddr_o  out  REG_AW  to WB, registered
wdata_o  out  32  to WB, registered
exc_o  out  1  one-cycle exception pulse, registered
exc_code_o  out  2  0=none 1=load misaligned 2=store misaligned 3=bus timeout
exc_addr_o  out  ADDR_W  faulting address

Behaviour:
Reset and state machine
- rst sampled at the rising edge.
- All outputs reset to 0; FSM goes to IDLE; timeout counter cleared.
- A reset mid-access drops ram_ce_o on the next edge; no WB write or exception is produced.
- FSM has two states, IDLE and BUSY.

IDLE
- in_valid_i=0: we_o=0 next cycle.
- in_valid_i=1, op=NONE: next cycle we_o=we_i, waddr_o=waddr_i, wdata_o=wdata_i. Latency 1; no stall.
- in_valid_i=1, memory op, misaligned:
  - misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0;
  - no RAM request; next cycle exc_o=1 with code 1 (load) or 2 (store), exc_addr_o=mem_addr_i, we_o=0; no stall.
- in_valid_i=1, aligned memory op:
  - latch op, addr, data, waddr and we, then go to BUSY;
  - stall_o=1 combinationally in this cycle.

BUSY
- ram_ce_o=1, driven from registered copies that are stable for the whole access.
- ram_we_o=1 for SB/SH/SW.
- ram_sel_o, little-endian lanes:
  - byte ops: one-hot of addr[1:0];
  - half ops: 0011 when addr[1]=0, 1100 when addr[1]=1;
  - word ops: 1111.
- ram_wdata_o: byte ops {4{d[7:0]}}; half ops {2{d[15:0]}}; word ops d.
- stall_o = !ram_ack_i. The ack cycle releases the stall so upstream advances on that same edge.
- On ram_ack_i, loads:
  - extract the lane selected by addr;
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word;
  - register the result into wdata_o, with we_o=latched we, next cycle;
  - return to IDLE.
- On ram_ack_i, stores: we_o=0 next cycle; return to IDLE.
- ram_ce_o deasserts on the edge after the ack, so it is never high for more than one access per accepted op.
- Minimum load latency is 2 cycles (accept, ack in the first BUSY cycle).

Timeout
- The counter increments each BUSY cycle without ack.
- When TIMEOUT!=0 and the count reaches TIMEOUT-1 with no ack:
  - abort: IDLE next cycle, ram_ce_o=0;
  - exc_o=1, code 3, exc_addr_o = latched address; we_o=0;
  - stall released in the abort cycle.
- An ack arriving in the same cycle as the timeout wins: normal completion, no exception.

Other
- exc_o/exc_code_o are high for exactly one cycle; exc_code_o=0 whenever exc_o=0.
- The registered WB outputs hold their last value only while we_o=0 is irrelevant. Each accepted instruction updates we_o exactly once.

Test Plan:
1. LB at addr 0x103, RAM word 0x80FF_1234, ack after 2 wait cycles -> sel=1000; stall high 3 cycles (accept + 2 BUSY); wdata_o=0xFFFF_FF80, we_o=1.
2. LHU at 0x102, word 0x8001_7FFF, immediate ack -> sel=1100, wdata_o=0x0000_8001; LH at 0x100 on same word -> 0x0000_7FFF.
3. SH at 0x202, data 0x1234_ABCD -> ram_we_o=1, sel=1100, ram_wdata_o=0xABCD_ABCD, ram_addr_o=0x200; we_o=0 after ack.
4. LW at 0x301 -> no ram_ce_o; exc_o pulse, code 1, exc_addr_o=0x301; stall_o never high.
5. TIMEOUT=4, SW with ack held low -> stall high 4 cycles, then exc_o code 3, ram_ce_o drops, FSM in IDLE. Repeat with ack on the 4th cycle -> normal completion, no exc.
6. Back-to-back ALU op (we=1, waddr=7, wdata=0x55), LW, ALU op, with rst asserted during the LW's BUSY -> ALU result on WB after 1 cycle; reset clears all outputs; no WB write from the LW.
